// File: rtl/st_pkg.sv
`default_nettype none
// ============================================================================
// Module   : st_pkg
// Purpose  : Shared constants for the stack issue/sequencing stage: op_sel
//            one-hot codes, Thumb opcode match masks/values, default sizes
//            and the issue FSM state type.
// Revision : 1.0 - initial release
// ============================================================================
package st_pkg;

  // Default cycle count of a PUSH/POP walk (idle + 9 list slots + terminal)
  localparam int SEQ_CYCLES_DEF = 11;
  // Default byte-offset width (imm8*4 peaks at 1020)
  localparam int OFF_W_DEF      = 10;

  // One-hot op select presented to the stack controller
  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_PUSH  = 8'h01;
  localparam logic [7:0] OP_POP   = 8'h02;
  localparam logic [7:0] OP_ADDSP = 8'h04;
  localparam logic [7:0] OP_SUBSP = 8'h08;
  localparam logic [7:0] OP_MOVSP = 8'h10;
  localparam logic [7:0] OP_ADDS  = 8'h20;
  localparam logic [7:0] OP_LDRSP = 8'h40;
  localparam logic [7:0] OP_STRSP = 8'h80;

  // Thumb encodings: (inst & MASK) == VAL
  localparam logic [15:0] MASK_PUSHPOP = 16'hFE00;
  localparam logic [15:0] VAL_PUSH     = 16'hB400;
  localparam logic [15:0] VAL_POP      = 16'hBC00;
  localparam logic [15:0] MASK_SPADJ   = 16'hFF80;
  localparam logic [15:0] VAL_ADDSP    = 16'hB000;
  localparam logic [15:0] VAL_SUBSP    = 16'hB080;
  localparam logic [15:0] MASK_MOVSP   = 16'hFFF8;
  localparam logic [15:0] VAL_MOVSP    = 16'h4668;
  localparam logic [15:0] MASK_SPREL   = 16'hF800;
  localparam logic [15:0] VAL_ADDS     = 16'hA800;
  localparam logic [15:0] VAL_LDRSP    = 16'h9800;
  localparam logic [15:0] VAL_STRSP    = 16'h9000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    SEQ  = 2'd2
  } state_e;

  function automatic logic op_match(input logic [15:0] inst,
                                    input logic [15:0] mask,
                                    input logic [15:0] val);
    return (inst & mask) == val;
  endfunction

endpackage
`default_nettype wire

// File: rtl/st_issue_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : st_issue_seq_if
// Purpose  : Fetch-side handshake plus decoded-op bus of the stack issue
//            stage. The illegal flag exists only when ST_ILLEGAL_TRAP_EN is
//            defined.
// Revision : 1.0 - initial release
// ============================================================================
interface st_issue_seq_if #(
  parameter int OFF_W = st_pkg::OFF_W_DEF
);
  logic             inst_valid;
  logic [15:0]      inst;
  logic             inst_ready;
  logic             flush;
  logic [7:0]       op_sel;
  logic [8:0]       RL;
  logic [2:0]       Rd0;
  logic [2:0]       Rd1;
  logic [OFF_W-1:0] imm_off;
  logic             ST_Wen;
  logic             busy;
`ifdef ST_ILLEGAL_TRAP_EN
  logic             illegal;
`endif

  // Upstream side: drives instructions/flush, observes the issued op
  modport master (
    output inst_valid, inst, flush,
    input  inst_ready, op_sel, RL, Rd0, Rd1, imm_off, ST_Wen, busy
`ifdef ST_ILLEGAL_TRAP_EN
    , input illegal
`endif
  );

  // Issue stage side
  modport slave (
    input  inst_valid, inst, flush,
    output inst_ready, op_sel, RL, Rd0, Rd1, imm_off, ST_Wen, busy
`ifdef ST_ILLEGAL_TRAP_EN
    , output illegal
`endif
  );
endinterface
`default_nettype wire

// File: rtl/st_inst_decode.sv
`default_nettype none
// ============================================================================
// Module   : st_inst_decode
// Purpose  : Combinational decode of a 16-bit Thumb stack-class instruction
//            into op_sel, register list, register fields and byte offset.
//            Anything not recognised (including empty-list PUSH/POP) decodes
//            as NOP and raises illegal_o.
// Revision : 1.0 - initial release
// ============================================================================
module st_inst_decode
  import st_pkg::*;
#(
  parameter int OFF_W = OFF_W_DEF
) (
  input  logic [15:0]      inst_i,
  output logic [7:0]       op_sel_o,
  output logic [8:0]       rl_o,
  output logic [2:0]       rd0_o,
  output logic [2:0]       rd1_o,
  output logic [OFF_W-1:0] imm_off_o,
  output logic             illegal_o
);

  // Priority decode; encodings are disjoint so order only affects readability
  always_comb begin
    op_sel_o  = OP_NOP;
    rl_o      = '0;
    rd0_o     = '0;
    rd1_o     = '0;
    imm_off_o = '0;
    if (op_match(inst_i, MASK_PUSHPOP, VAL_PUSH) && (inst_i[8:0] != 9'd0)) begin
      op_sel_o = OP_PUSH;
      rl_o     = inst_i[8:0];
    end else if (op_match(inst_i, MASK_PUSHPOP, VAL_POP) && (inst_i[8:0] != 9'd0)) begin
      op_sel_o = OP_POP;
      rl_o     = inst_i[8:0];
    end else if (op_match(inst_i, MASK_SPADJ, VAL_ADDSP)) begin
      op_sel_o  = OP_ADDSP;
      imm_off_o = OFF_W'({inst_i[6:0], 2'b00});
    end else if (op_match(inst_i, MASK_SPADJ, VAL_SUBSP)) begin
      op_sel_o  = OP_SUBSP;
      imm_off_o = OFF_W'({inst_i[6:0], 2'b00});
    end else if (op_match(inst_i, MASK_MOVSP, VAL_MOVSP)) begin
      op_sel_o = OP_MOVSP;
      rd0_o    = inst_i[2:0];
    end else if (op_match(inst_i, MASK_SPREL, VAL_ADDS)) begin
      op_sel_o  = OP_ADDS;
      rd1_o     = inst_i[10:8];
      imm_off_o = OFF_W'({inst_i[7:0], 2'b00});
    end else if (op_match(inst_i, MASK_SPREL, VAL_LDRSP)) begin
      op_sel_o  = OP_LDRSP;
      rd1_o     = inst_i[10:8];
      imm_off_o = OFF_W'({inst_i[7:0], 2'b00});
    end else if (op_match(inst_i, MASK_SPREL, VAL_STRSP)) begin
      op_sel_o  = OP_STRSP;
      rd1_o     = inst_i[10:8];
      imm_off_o = OFF_W'({inst_i[7:0], 2'b00});
    end
    illegal_o = (op_sel_o == OP_NOP);
  end

endmodule
`default_nettype wire

// File: rtl/st_issue_seq.sv
`default_nettype none
// ============================================================================
// Module   : st_issue_seq
// Purpose  : Issue/sequencing stage in front of the stack controller. Accepts
//            one Thumb stack instruction per handshake, registers the decoded
//            op and holds it with ST_Wen high for 1 cycle (single-cycle ops)
//            or SEQ_CYCLES cycles (PUSH/POP), back-pressuring fetch meanwhile.
//            Optional macro ST_ILLEGAL_TRAP_EN adds a sticky illegal flag
//            that halts issue until reset.
// Revision : 1.0 - initial release
// ============================================================================
module st_issue_seq
  import st_pkg::*;
#(
  parameter int SEQ_CYCLES = SEQ_CYCLES_DEF,
  parameter int OFF_W      = OFF_W_DEF
) (
  input  logic          clk,
  input  logic          reset,
  st_issue_seq_if.slave bus
);

  localparam int CNT_W = $clog2(SEQ_CYCLES + 1);

  // Decoder results act as next-state values for the output registers
  logic [7:0]       op_sel_d;
  logic [8:0]       rl_d;
  logic [2:0]       rd0_d;
  logic [2:0]       rd1_d;
  logic [OFF_W-1:0] imm_off_d;
  logic             illegal_d;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       op_sel_q;
  logic [8:0]       rl_q;
  logic [2:0]       rd0_q;
  logic [2:0]       rd1_q;
  logic [OFF_W-1:0] imm_off_q;
  logic             st_wen_q;
  logic             busy_q;
`ifdef ST_ILLEGAL_TRAP_EN
  logic             illegal_q;
`endif

  logic ready_w;
  logic accept_w;
  logic multi_w;

  st_inst_decode #(.OFF_W(OFF_W)) u_dec (
    .inst_i    (bus.inst),
    .op_sel_o  (op_sel_d),
    .rl_o      (rl_d),
    .rd0_o     (rd0_d),
    .rd1_o     (rd1_d),
    .imm_off_o (imm_off_d),
    .illegal_o (illegal_d)
  );

  // Ready on the last cycle of any op so a new one issues without a bubble
  always_comb begin
    ready_w = (state_q == IDLE) || (state_q == EXEC) ||
              ((state_q == SEQ) && (cnt_q == '0));
`ifdef ST_ILLEGAL_TRAP_EN
    ready_w = ready_w && !illegal_q;
`endif
  end

  assign accept_w = bus.inst_valid && ready_w;
  assign multi_w  = (op_sel_d == OP_PUSH) || (op_sel_d == OP_POP);

  // Issue FSM with walk counter and registered op outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_sel_q  <= OP_NOP;
      rl_q      <= '0;
      rd0_q     <= '0;
      rd1_q     <= '0;
      imm_off_q <= '0;
      st_wen_q  <= 1'b0;
      busy_q    <= 1'b0;
`ifdef ST_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      if (accept_w && !bus.flush && !illegal_d) begin
        // New op: PUSH/POP walk the list, everything else takes one cycle
        state_q   <= multi_w ? SEQ : EXEC;
        cnt_q     <= multi_w ? CNT_W'(SEQ_CYCLES - 1) : '0;
        op_sel_q  <= op_sel_d;
        rl_q      <= rl_d;
        rd0_q     <= rd0_d;
        rd1_q     <= rd1_d;
        imm_off_q <= imm_off_d;
        st_wen_q  <= 1'b1;
        busy_q    <= 1'b1;
      end else if (!bus.flush && !accept_w && (state_q == SEQ) && (cnt_q != '0)) begin
        // Mid-walk: hold the op, count down
        cnt_q <= cnt_q - CNT_W'(1);
      end else begin
        // Flush, NOP accept, or op finished with nothing new: back to idle
        state_q   <= IDLE;
        cnt_q     <= '0;
        op_sel_q  <= OP_NOP;
        rl_q      <= '0;
        rd0_q     <= '0;
        rd1_q     <= '0;
        imm_off_q <= '0;
        st_wen_q  <= 1'b0;
        busy_q    <= 1'b0;
      end
`ifdef ST_ILLEGAL_TRAP_EN
      if (accept_w && !bus.flush && illegal_d) begin
        illegal_q <= 1'b1;
      end
`endif
    end
  end

  assign bus.inst_ready = ready_w;
  assign bus.op_sel     = op_sel_q;
  assign bus.RL         = rl_q;
  assign bus.Rd0        = rd0_q;
  assign bus.Rd1        = rd1_q;
  assign bus.imm_off    = imm_off_q;
  assign bus.ST_Wen     = st_wen_q;
  assign bus.busy       = busy_q;
`ifdef ST_ILLEGAL_TRAP_EN
  assign bus.illegal    = illegal_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_st_issue_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_st_issue_seq
// Purpose  : Directed self-checking bench for st_issue_seq. Each cycle the
//            full output bundle {op_sel, RL, Rd0, Rd1, imm_off, ST_Wen, busy,
//            inst_ready} is compared against hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_st_issue_seq;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  st_issue_seq_if bus ();

  st_issue_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // {op_sel[8], RL[9], Rd0[3], Rd1[3], imm_off[10], ST_Wen, busy, inst_ready}
  logic [35:0] obs;
  assign obs = {bus.op_sel, bus.RL, bus.Rd0, bus.Rd1, bus.imm_off,
                bus.ST_Wen, bus.busy, bus.inst_ready};

  localparam logic [35:0] IDLE_V = {8'h00, 9'h000, 3'd0, 3'd0, 10'd0, 1'b0, 1'b0, 1'b1};

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    bus.inst_valid = 1'b0;
    bus.inst       = 16'h0000;
    bus.flush      = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();
    checks++;
    if (obs !== IDLE_V) begin
      errors++;
      $display("FAIL reset got=%h exp=%h", obs, IDLE_V);
    end
  endtask

  task automatic test_push();
    logic [35:0] exp;
    bus.inst       = 16'hB510;
    bus.inst_valid = 1'b1;
    checks++;
    if (bus.inst_ready !== 1'b1) begin
      errors++;
      $display("FAIL push_ready_c0 got=%b exp=1", bus.inst_ready);
    end
    step();
    bus.inst_valid = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      exp = {8'h01, 9'h110, 3'd0, 3'd0, 10'd0, 1'b1, 1'b1, (c == 11)};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL push c=%0d got=%h exp=%h", c, obs, exp);
      end
      step();
    end
    checks++;
    if (obs !== IDLE_V) begin
      errors++;
      $display("FAIL push_end got=%h exp=%h", obs, IDLE_V);
    end
  endtask

  task automatic test_back_to_back();
    logic [35:0] exp;
    bus.inst       = 16'hB082;
    bus.inst_valid = 1'b1;
    step();
    exp = {8'h08, 9'h000, 3'd0, 3'd0, 10'd8, 1'b1, 1'b1, 1'b1};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL b2b_subsp got=%h exp=%h", obs, exp);
    end
    bus.inst = 16'h9A03;
    step();
    bus.inst_valid = 1'b0;
    exp = {8'h40, 9'h000, 3'd0, 3'd2, 10'd12, 1'b1, 1'b1, 1'b1};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL b2b_ldrsp got=%h exp=%h", obs, exp);
    end
    step();
    checks++;
    if (obs !== IDLE_V) begin
      errors++;
      $display("FAIL b2b_end got=%h exp=%h", obs, IDLE_V);
    end
  endtask

  task automatic test_flush();
    logic [35:0] exp;
    bus.inst       = 16'hBD0F;
    bus.inst_valid = 1'b1;
    step();
    bus.inst_valid = 1'b0;
    exp = {8'h02, 9'h10F, 3'd0, 3'd0, 10'd0, 1'b1, 1'b1, 1'b0};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL pop_c1 got=%h exp=%h", obs, exp);
    end
    repeat (3) step();
    // cycle 4: flush with a MOV offered alongside
    bus.flush      = 1'b1;
    bus.inst       = 16'h4669;
    bus.inst_valid = 1'b1;
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL pop_c4 got=%h exp=%h", obs, exp);
    end
    step();
    checks++;
    if (obs !== IDLE_V) begin
      errors++;
      $display("FAIL flush_c5 got=%h exp=%h", obs, IDLE_V);
    end
    // flush still high while ready: the offered MOV must be dropped
    step();
    bus.flush      = 1'b0;
    bus.inst_valid = 1'b0;
    checks++;
    if (obs !== IDLE_V) begin
      errors++;
      $display("FAIL flush_drop got=%h exp=%h", obs, IDLE_V);
    end
  endtask

  task automatic test_single_ops();
    logic [35:0] exp;
    bus.inst       = 16'h466A;
    bus.inst_valid = 1'b1;
    step();
    bus.inst_valid = 1'b0;
    exp = {8'h10, 9'h000, 3'd2, 3'd0, 10'd0, 1'b1, 1'b1, 1'b1};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL movsp got=%h exp=%h", obs, exp);
    end
    step();
    checks++;
    if (obs !== IDLE_V) begin
      errors++;
      $display("FAIL movsp_1cyc got=%h exp=%h", obs, IDLE_V);
    end
    bus.inst       = 16'hAB05;
    bus.inst_valid = 1'b1;
    step();
    exp = {8'h20, 9'h000, 3'd0, 3'd3, 10'd20, 1'b1, 1'b1, 1'b1};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL adds got=%h exp=%h", obs, exp);
    end
    bus.inst = 16'h90FF;
    step();
    exp = {8'h80, 9'h000, 3'd0, 3'd0, 10'd1020, 1'b1, 1'b1, 1'b1};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL strsp_max got=%h exp=%h", obs, exp);
    end
    bus.inst = 16'hB07F;
    step();
    bus.inst_valid = 1'b0;
    exp = {8'h04, 9'h000, 3'd0, 3'd0, 10'd508, 1'b1, 1'b1, 1'b1};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL addsp_max got=%h exp=%h", obs, exp);
    end
    step();
    checks++;
    if (obs !== IDLE_V) begin
      errors++;
      $display("FAIL single_end got=%h exp=%h", obs, IDLE_V);
    end
  endtask

  task automatic test_reset_mid_op();
    bus.inst       = 16'hB510;
    bus.inst_valid = 1'b1;
    step();
    bus.inst_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (obs !== IDLE_V) begin
      errors++;
      $display("FAIL rst_mid got=%h exp=%h", obs, IDLE_V);
    end
    step();
    checks++;
    if (obs !== IDLE_V) begin
      errors++;
      $display("FAIL rst_mid_after got=%h exp=%h", obs, IDLE_V);
    end
  endtask

  task automatic test_nop();
    logic [35:0] exp;
`ifdef ST_ILLEGAL_TRAP_EN
    exp = {8'h00, 9'h000, 3'd0, 3'd0, 10'd0, 1'b0, 1'b0, 1'b0};
`else
    exp = IDLE_V;
`endif
    bus.inst       = 16'hB400;
    bus.inst_valid = 1'b1;
    step();
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL nop_empty_push got=%h exp=%h", obs, exp);
    end
`ifdef ST_ILLEGAL_TRAP_EN
    checks++;
    if (bus.illegal !== 1'b1) begin
      errors++;
      $display("FAIL illegal_set got=%b exp=1", bus.illegal);
    end
`endif
    bus.inst = 16'h1234;
    step();
    bus.inst_valid = 1'b0;
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL nop_1234 got=%h exp=%h", obs, exp);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    checks++;
    if (obs !== IDLE_V) begin
      errors++;
      $display("FAIL nop_reset got=%h exp=%h", obs, IDLE_V);
    end
`ifdef ST_ILLEGAL_TRAP_EN
    checks++;
    if (bus.illegal !== 1'b0) begin
      errors++;
      $display("FAIL illegal_clear got=%b exp=0", bus.illegal);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_push();
    test_back_to_back();
    test_flush();
    test_single_ops();
    test_reset_mid_op();
    test_nop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
